uart_rx_unit: RTL and testbench

//  Serial receiver for the debugger unit: deserialises 8N1 UART frames from the host and feeds
//  the debugger control FSM (command bytes idle/load/fast/step, program-memory load bytes).

---
 rtl/uart_rx_unit_if.sv | 24 ++
 rtl/uart_rx_unit.sv | 152 +++++++++++++++
 tb/tb_uart_rx_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_unit_if.sv
// Receive-side bundle from the UART receiver to the debugger control FSM.
// master: receiver drives byte, done/frame-error strobes and busy; slave: consumer.
interface uart_rx_unit_if #(
    parameter int DBIT = 8
);
    logic [DBIT-1:0] o_rx_data;
    logic            os_rx_done;
    logic            os_frame_err;
    logic            o_busy;

    modport master (
        output o_rx_data,
        output os_rx_done,
        output os_frame_err,
        output o_busy
    );

    modport slave (
        input o_rx_data,
        input os_rx_done,
        input os_frame_err,
        input o_busy
    );
endinterface

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with 16x oversampling tick generator and framing check.
// Ports: clk, rst (async active-low), i_rx (serial line), rx_if (byte + strobes + busy).
module uart_rx_unit #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 9600,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx,
    uart_rx_unit_if.master   rx_if
);

    localparam int TICK_DIV = CLK_HZ / (16 * BAUD);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            rx_s;
    logic            tick;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    // Counter parked at 0 while idle so the tick phase starts at the edge.
    assign cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], i_rx};
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d  = '0;
                        sh_d = {rx_s, sh_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            data_d  = sh_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BRK;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            BRK: begin
                // Only a returning high line re-arms start detection.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    assign rx_if.o_rx_data    = data_q;
    assign rx_if.os_rx_done   = done_q;
    assign rx_if.os_frame_err = ferr_q;
    assign rx_if.o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed self-checking bench for uart_rx_unit.
// Two instances: TICK_DIV=1 (16 clk/bit) and TICK_DIV=3 (48 clk/bit).
module tb_uart_rx_unit;

    logic clk;
    logic rst;
    logic rx1;
    logic rx3;

    int tests;
    int fails;
    int cyc;

    int done1, ferr1, done_cyc1;
    int done3, ferr3, done_cyc3;
    logic [7:0] got1[$];
    logic [7:0] got3[$];

    uart_rx_unit_if #(.DBIT(8)) if1 ();
    uart_rx_unit_if #(.DBIT(8)) if3 ();

    uart_rx_unit #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000),
        .DBIT   (8),
        .SB_TICK(16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .i_rx (rx1),
        .rx_if(if1.master)
    );

    uart_rx_unit #(
        .CLK_HZ (4_800_000),
        .BAUD   (100_000),
        .DBIT   (8),
        .SB_TICK(16)
    ) dut3 (
        .clk  (clk),
        .rst  (rst),
        .i_rx (rx3),
        .rx_if(if3.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if1.os_rx_done) begin
            done1++;
            done_cyc1 = cyc;
            got1.push_back(if1.o_rx_data);
        end
        if (if1.os_frame_err) ferr1++;
        if (if3.os_rx_done) begin
            done3++;
            done_cyc3 = cyc;
            got3.push_back(if3.o_rx_data);
        end
        if (if3.os_frame_err) ferr3++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx3 = v;
        else rx1 = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bp,
                              input logic stopv, input bit sel);
        set_line(sel, 1'b0);
        wait_cyc(bp);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            wait_cyc(bp);
        end
        set_line(sel, stopv);
        wait_cyc(bp);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        tests++;
        if (if1.o_rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got %h want 00", if1.o_rx_data);
        end
        tests++;
        if (if1.os_rx_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got %b want 0", if1.os_rx_done);
        end
        tests++;
        if (if1.os_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ferr got %b want 0", if1.os_frame_err);
        end
        tests++;
        if (if1.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", if1.o_busy);
        end
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_single;
        int t0, d0, lat;
        d0 = done1;
        got1.delete();
        t0 = cyc;
        send_frame(8'h01, 16, 1'b1, 1'b0);
        wait_cyc(10);
        lat = done_cyc1 - t0;
        tests++;
        if (done1 - d0 !== 1) begin
            fails++;
            $display("FAIL single_count got %0d want 1", done1 - d0);
        end
        tests++;
        if (got1.size() != 1 || got1[0] !== 8'h01) begin
            fails++;
            $display("FAIL single_data got %p want 01", got1);
        end
        tests++;
        if (lat < 152 || lat > 156) begin
            fails++;
            $display("FAIL single_latency got %0d want 152..156", lat);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done1;
        got1.delete();
        send_frame(8'h03, 16, 1'b1, 1'b0);
        send_frame(8'hA5, 16, 1'b1, 1'b0);
        wait_cyc(10);
        tests++;
        if (done1 - d0 !== 2) begin
            fails++;
            $display("FAIL b2b_count got %0d want 2", done1 - d0);
        end
        tests++;
        if (got1.size() != 2 || got1[0] !== 8'h03 || got1[1] !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_data got %p want 03 a5", got1);
        end
        tests++;
        if (ferr1 !== 0) begin
            fails++;
            $display("FAIL b2b_ferr got %0d want 0", ferr1);
        end
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = done1;
        f0 = ferr1;
        rx1 = 1'b0;
        wait_cyc(4);
        rx1 = 1'b1;
        wait_cyc(30);
        tests++;
        if (done1 - d0 !== 0 || ferr1 - f0 !== 0) begin
            fails++;
            $display("FAIL glitch_strobes got done %0d ferr %0d want 0 0",
                     done1 - d0, ferr1 - f0);
        end
        tests++;
        if (if1.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy got %b want 0", if1.o_busy);
        end
        tests++;
        if (if1.o_rx_data !== 8'hA5) begin
            fails++;
            $display("FAIL glitch_data got %h want a5", if1.o_rx_data);
        end
    endtask

    task automatic test_frame_err;
        int d0, f0;
        d0 = done1;
        f0 = ferr1;
        got1.delete();
        send_frame(8'h55, 16, 1'b0, 1'b0);
        wait_cyc(48);
        tests++;
        if (if1.o_busy !== 1'b1) begin
            fails++;
            $display("FAIL brk_busy got %b want 1", if1.o_busy);
        end
        rx1 = 1'b1;
        wait_cyc(20);
        tests++;
        if (ferr1 - f0 !== 1) begin
            fails++;
            $display("FAIL ferr_count got %0d want 1", ferr1 - f0);
        end
        tests++;
        if (done1 - d0 !== 0) begin
            fails++;
            $display("FAIL ferr_done got %0d want 0", done1 - d0);
        end
        tests++;
        if (if1.o_rx_data !== 8'hA5) begin
            fails++;
            $display("FAIL ferr_data got %h want a5", if1.o_rx_data);
        end
        send_frame(8'h02, 16, 1'b1, 1'b0);
        wait_cyc(10);
        tests++;
        if (got1.size() != 1 || if1.o_rx_data !== 8'h02) begin
            fails++;
            $display("FAIL ferr_next got %h n %0d want 02 n 1",
                     if1.o_rx_data, got1.size());
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        int d0;
        b = 8'h7E;
        rx1 = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 3; i++) begin
            rx1 = b[i];
            wait_cyc(16);
        end
        rx1 = b[3];
        wait_cyc(8);
        rst = 1'b0;
        #1;
        tests++;
        if (if1.o_rx_data !== 8'h00 || if1.os_rx_done !== 1'b0 ||
            if1.os_frame_err !== 1'b0 || if1.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_outs got %h %b %b %b want 00 0 0 0",
                     if1.o_rx_data, if1.os_rx_done,
                     if1.os_frame_err, if1.o_busy);
        end
        rx1 = 1'b1;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(20);
        d0 = done1;
        got1.delete();
        send_frame(8'h02, 16, 1'b1, 1'b0);
        wait_cyc(10);
        tests++;
        if (done1 - d0 !== 1 || if1.o_rx_data !== 8'h02) begin
            fails++;
            $display("FAIL midrst_next got %h n %0d want 02 n 1",
                     if1.o_rx_data, done1 - d0);
        end
    endtask

    task automatic test_tick_div3;
        int t0, lat;
        got3.delete();
        t0 = cyc;
        send_frame(8'hFF, 48, 1'b1, 1'b1);
        send_frame(8'h00, 48, 1'b1, 1'b1);
        wait_cyc(20);
        tests++;
        if (got3.size() != 2 || got3[0] !== 8'hFF || got3[1] !== 8'h00) begin
            fails++;
            $display("FAIL div3_data got %p want ff 00", got3);
        end
        tests++;
        if (ferr3 !== 0) begin
            fails++;
            $display("FAIL div3_ferr got %0d want 0", ferr3);
        end
        got3.delete();
        t0 = cyc;
        send_frame(8'h5A, 48, 1'b1, 1'b1);
        wait_cyc(20);
        lat = done_cyc3 - t0;
        tests++;
        if (lat < 456 || lat > 460 || got3.size() != 1 || got3[0] !== 8'h5A) begin
            fails++;
            $display("FAIL div3_latency got %0d n %0d want 456..460 n 1",
                     lat, got3.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        done1 = 0;
        ferr1 = 0;
        done_cyc1 = 0;
        done3 = 0;
        ferr3 = 0;
        done_cyc3 = 0;
        rx1 = 1'b1;
        rx3 = 1'b1;
        rst = 1'b1;
        wait_cyc(2);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
        test_tick_div3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
